spike_packet_receiver: RTL and testbench

- Destination-side counterpart of the mesh injection controller. Sits on a neuron tile's router local port and accepts 32-bit spike packets pushed by the router.
- Accumulates received spikes per time step into a double-buffered axon bitmap.
- After each step-boundary `start` pulse, serially replays the previous step's spikes to the neuron core as axon indices, using a valid/ready handshake.

---
 rtl/spike_packet_receiver.sv | 185 ++++++++++++++++++
 tb/tb_spike_packet_receiver.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_packet_receiver.sv
// Spike packet receiver: collects one step's spikes into a double-buffered axon bitmap and replays the previous step serially.
// Optional macro MISROUTE_CHECK_EN: drop packets whose destination is not this tile, and count the drops.
module spike_packet_receiver #(
   parameter int         AXON_W = 8,
   parameter logic [3:0] TILE_X = 4'd0,
   parameter logic [3:0] TILE_Y = 4'd0
) (
   input  logic              neu_clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pkt_valid,
   input  logic [31:0]       pkt_data,
   output logic              spike_valid,
   output logic [AXON_W-1:0] spike_axon,
   input  logic              spike_ready,
   output logic              step_done,
   output logic              overrun,
   output logic [15:0]       drop_count
);

   localparam int NUM_AXON = 2 ** AXON_W;

   typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

   state_t              state_q, state_d;
   logic [AXON_W-1:0]   idx_q, idx_d;
   logic                wr_sel_q, wr_sel_d;
   logic [NUM_AXON-1:0] bank0_q, bank0_d;
   logic [NUM_AXON-1:0] bank1_q, bank1_d;
   logic                overrun_q, overrun_d;
   logic                pkt_accept;
   logic [AXON_W-1:0]   pkt_axon;
   logic                rd_bit;
   logic                last_idx;
   logic                clear_bit;
   logic                clear_all;
   logic                unused_pkt_bits;

   assign pkt_axon        = pkt_data[AXON_W-1:0];
   assign unused_pkt_bits = ^pkt_data;
   assign last_idx        = &idx_q;
   // wr_sel_q selects the write bank; the other bank is being replayed.
   assign rd_bit          = wr_sel_q ? bank0_q[idx_q] : bank1_q[idx_q];

`ifdef MISROUTE_CHECK_EN
   logic        pkt_match;
   logic [15:0] drop_q, drop_d;

   assign pkt_match  = (pkt_data[31:28] == TILE_X) && (pkt_data[27:24] == TILE_Y);
   assign pkt_accept = pkt_valid && pkt_match;
   assign drop_count = drop_q;

   always_comb begin
      drop_d = drop_q;
      if (pkt_valid && !pkt_match && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge neu_clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 16'd0;
      end else begin
         drop_q <= drop_d;
      end
   end
`else
   assign pkt_accept = pkt_valid;
   assign drop_count = 16'd0;
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_sel_d  = wr_sel_q;
      overrun_d = overrun_q;
      clear_bit = 1'b0;
      clear_all = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            if (start) begin
               clear_all = 1'b1;
            end else if (rd_bit) begin
               state_d = EMIT;
            end else if (last_idx) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         EMIT: begin
            if (start) begin
               clear_all = 1'b1;
            end else if (spike_ready) begin
               clear_bit = 1'b1;
               if (last_idx) begin
                  state_d = DONE;
               end else begin
                  state_d = SCAN;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (start) begin
               state_d = SCAN;
               idx_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // An aborted scan restarts from index 0 on the freshly swapped bank.
      if (clear_all) begin
         overrun_d = 1'b1;
         state_d   = SCAN;
         idx_d     = '0;
      end

      if (start) begin
         wr_sel_d = ~wr_sel_q;
      end
   end

   // Clears hit the current read bank; the packet lands in the post-swap write bank,
   // so a bulk clear and a same-cycle packet to the same bank keep the packet.
   always_comb begin
      bank0_d = bank0_q;
      bank1_d = bank1_q;
      if (clear_all) begin
         if (wr_sel_q) begin
            bank0_d = '0;
         end else begin
            bank1_d = '0;
         end
      end
      if (clear_bit) begin
         if (wr_sel_q) begin
            bank0_d[idx_q] = 1'b0;
         end else begin
            bank1_d[idx_q] = 1'b0;
         end
      end
      if (pkt_accept) begin
         if (wr_sel_d) begin
            bank1_d[pkt_axon] = 1'b1;
         end else begin
            bank0_d[pkt_axon] = 1'b1;
         end
      end
   end

   always_ff @(posedge neu_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wr_sel_q  <= 1'b0;
         bank0_q   <= '0;
         bank1_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wr_sel_q  <= wr_sel_d;
         bank0_q   <= bank0_d;
         bank1_q   <= bank1_d;
         overrun_q <= overrun_d;
      end
   end

   assign spike_valid = (state_q == EMIT);
   assign spike_axon  = (state_q == EMIT) ? idx_q : '0;
   assign step_done   = (state_q == DONE);
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_spike_packet_receiver.sv
// Scoreboard bench for spike_packet_receiver: stimulus pushes expected replays per step, a negedge monitor pops and compares.
module tb_spike_packet_receiver;

   localparam int AXON_W   = 8;
   localparam int NUM_AXON = 2 ** AXON_W;
`ifdef MISROUTE_CHECK_EN
   localparam logic [3:0] TX = 4'd1;
   localparam logic [3:0] TY = 4'd2;
`else
   localparam logic [3:0] TX = 4'd0;
   localparam logic [3:0] TY = 4'd0;
`endif

   logic              neu_clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              pkt_valid = 1'b0;
   logic [31:0]       pkt_data = '0;
   logic              spike_valid;
   logic [AXON_W-1:0] spike_axon;
   logic              spike_ready = 1'b0;
   logic              step_done;
   logic              overrun;
   logic [15:0]       drop_count;

   spike_packet_receiver #(.AXON_W(AXON_W), .TILE_X(TX), .TILE_Y(TY)) dut (
      .neu_clk(neu_clk), .rst_n(rst_n), .start(start), .pkt_valid(pkt_valid),
      .pkt_data(pkt_data), .spike_valid(spike_valid), .spike_axon(spike_axon),
      .spike_ready(spike_ready), .step_done(step_done), .overrun(overrun),
      .drop_count(drop_count)
   );

   always #5 neu_clk = ~neu_clk;

   typedef struct {
      int id;
      bit done;
      int axon;
   } exp_t;

   exp_t q[$];
   bit   cur[NUM_AXON];
   int   next_id = 0;
   bit   exp_overrun = 0;
   int   exp_drops = 0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cyc = 0;

   always @(posedge neu_clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit accepted(input logic [3:0] dx, input logic [3:0] dy);
`ifdef MISROUTE_CHECK_EN
      return (dx == TX) && (dy == TY);
`else
      return 1'b1;
`endif
   endfunction

   // Reference model: a step's spikes are the set of accepted axons; replay lists them ascending, then done.
   task automatic model_start();
      for (int a = 0; a < NUM_AXON; a++) begin
         if (cur[a]) q.push_back('{next_id, 1'b0, a});
         cur[a] = 1'b0;
      end
      q.push_back('{next_id, 1'b1, 0});
      next_id++;
   endtask

   // A previous step still owning entries after the start edge was aborted.
   task automatic model_after_start();
      exp_t keep[$];
      bit   ab = 0;
      int   newest = next_id - 1;
      foreach (q[i]) begin
         if (q[i].id < newest) ab = 1;
         else keep.push_back(q[i]);
      end
      if (ab) begin
         exp_overrun = 1;
         q = keep;
      end
   endtask

   task automatic model_pkt(input logic [3:0] dx, input logic [3:0] dy, input int ax);
      if (accepted(dx, dy)) cur[ax] = 1'b1;
      else if (exp_drops < 65535) exp_drops++;
   endtask

   task automatic do_cycle(input bit st, input bit pv, input logic [3:0] dx,
                           input logic [3:0] dy, input int ax);
      start     = st;
      pkt_valid = pv;
      pkt_data  = {dx, dy, 16'h0, 8'(ax)};
      if (st) model_start();
      if (pv) model_pkt(dx, dy, ax);
      @(posedge neu_clk);
      if (st) model_after_start();
      #1;
      start     = 1'b0;
      pkt_valid = 1'b0;
      if (st) begin
         chk("overrun_after_start", overrun, exp_overrun);
         chk("drop_count", drop_count, exp_drops);
      end
   endtask

   task automatic pkt(input int ax);
      do_cycle(1'b0, 1'b1, TX, TY, ax);
   endtask

   task automatic drain(input bit rand_ready);
      int n = 0;
      while (q.size() != 0 && n < 4000) begin
         spike_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge neu_clk);
         #1;
         n++;
      end
      chk("drain_left", q.size(), 0);
      q.delete();
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!spike_valid && n < 600) begin
         @(posedge neu_clk);
         #1;
         n++;
      end
      chk("wait_valid", spike_valid, 1);
   endtask

   // Monitor: every accepted spike and every step_done must match the head of the scoreboard.
   always @(negedge neu_clk) begin
      if (rst_n) begin
         if (spike_valid && spike_ready) begin
            if (q.size() == 0) begin
               chk("spike_unexpected", spike_axon, 32'hFFFF_FFFF);
            end else begin
               chk("spike_kind", q[0].done, 0);
               chk("spike_axon", spike_axon, q[0].axon);
               void'(q.pop_front());
            end
         end
         if (step_done) begin
            done_cyc = cyc;
            if (q.size() == 0) begin
               chk("done_unexpected", step_done, 0);
            end else begin
               chk("done_kind", q[0].done, 1);
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      int start_cyc;
      int nsteps;
      logic [3:0] dx, dy;
      int ax;

      // Reset state
      repeat (3) @(posedge neu_clk);
      #1;
      chk("rst_spike_valid", spike_valid, 0);
      chk("rst_spike_axon", spike_axon, 0);
      chk("rst_step_done", step_done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_drop_count", drop_count, 0);
      rst_n = 1'b1;
      @(posedge neu_clk);
      #1;

      // Duplicates merge; timing of a full scan with ready held high
      spike_ready = 1'b1;
      pkt(3);
      pkt(200);
      pkt(3);
      start_cyc = cyc;
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      drain(1'b0);
      chk("scan_span", done_cyc - start_cyc + 1, NUM_AXON + 4);
      $display("step replay 3,200: span %0d cycles", done_cyc - start_cyc + 1);

      // Packet during replay belongs to the next step
      pkt(5);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      repeat (3) @(posedge neu_clk);
      #1;
      pkt(7);
      drain(1'b0);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      drain(1'b0);
      $display("concurrent write: replays 5 then 7 checked");

      // Backpressure holds the spike stable
      spike_ready = 1'b0;
      pkt(9);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         @(posedge neu_clk);
         #1;
         chk("stall_valid", spike_valid, 1);
         chk("stall_axon", spike_axon, 9);
      end
      drain(1'b0);
      $display("stall at axon 9: 10 cycles checked");

      // Start during EMIT aborts and clears the old read bank
      spike_ready = 1'b0;
      pkt(10);
      pkt(20);
      pkt(30);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      wait_valid();
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      chk("abort_valid_drop", spike_valid, 0);
      chk("abort_overrun", overrun, 1);
      drain(1'b0);
      pkt(77);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      drain(1'b0);
      $display("overrun abort: overrun=%0d", overrun);

      // Packet in the same cycle as start counts toward the next step
      do_cycle(1'b1, 1'b1, TX, TY, 42);
      drain(1'b0);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      drain(1'b0);
      $display("same-cycle start+packet axon 42 checked");

      // Destination check / drop counter
      do_cycle(1'b0, 1'b1, 4'd1, 4'd3, 11);
      chk("drop_count_after_misroute", drop_count, exp_drops);
      do_cycle(1'b0, 1'b1, 4'd1, 4'd2, 12);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      drain(1'b0);
      $display("misroute packets: drop_count=%0d", drop_count);

      // Randomized steps, random backpressure, starts landing anywhere in a replay
      for (int s = 0; s < 14; s++) begin
         nsteps = $urandom_range(20, 450);
         for (int c = 0; c < nsteps; c++) begin
            spike_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
               0:       ax = 0;
               1:       ax = NUM_AXON - 1;
               default: ax = $urandom_range(0, NUM_AXON - 1);
            endcase
            dx = ($urandom_range(0, 3) == 0) ? 4'($urandom) : TX;
            dy = ($urandom_range(0, 3) == 0) ? 4'($urandom) : TY;
            do_cycle(1'b0, ($urandom_range(0, 9) < 3), dx, dy, ax);
         end
         do_cycle(1'b1, ($urandom_range(0, 3) == 0), TX, TY, $urandom_range(0, NUM_AXON - 1));
         $display("random step %0d: %0d cycles, overrun=%0d drops=%0d", s, nsteps, overrun, drop_count);
      end
      drain(1'b1);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      drain(1'b1);

      // Reset mid-replay discards everything
      spike_ready = 1'b0;
      pkt(1);
      pkt(2);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      wait_valid();
      rst_n = 1'b0;
      q.delete();
      for (int a = 0; a < NUM_AXON; a++) cur[a] = 1'b0;
      exp_overrun = 0;
      exp_drops = 0;
      #1;
      chk("midrst_spike_valid", spike_valid, 0);
      chk("midrst_overrun", overrun, 0);
      chk("midrst_drop_count", drop_count, 0);
      @(posedge neu_clk);
      #1;
      rst_n = 1'b1;
      @(posedge neu_clk);
      #1;
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      drain(1'b0);
      do_cycle(1'b1, 1'b0, TX, TY, 0);
      drain(1'b0);
      $display("reset mid-replay: banks empty afterwards");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
